// File: rtl/accel_pkg.sv
// Shared constants for the CPU accelerator port: ID map, bus widths, accel_div FSM encoding.
package accel_pkg;
  localparam int ACCEL_ID_WIDTH   = 4;
  localparam int ACCEL_DATA_WIDTH = 16;

  localparam logic [ACCEL_ID_WIDTH-1:0] ACCEL_ID_NONE = 4'd0;
  localparam logic [ACCEL_ID_WIDTH-1:0] ACCEL_ID_DIV  = 4'd1;

  localparam logic [2:0] ST_WAIT_A = 3'd0;
  localparam logic [2:0] ST_WAIT_B = 3'd1;
  localparam logic [2:0] ST_BUSY   = 3'd2;
  localparam logic [2:0] ST_RES_Q  = 3'd3;
  localparam logic [2:0] ST_RES_R  = 3'd4;
endpackage

// File: rtl/accel_div_core.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, DATA_WIDTH cycles per divide.
module accel_div_core
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = ACCEL_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quot,
  output logic [DATA_WIDTH-1:0] o_rem
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [CW-1:0]         r_cnt;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_div;

  logic [DATA_WIDTH:0]   w_shift;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_diff;

  // r_q starts as the dividend; its MSB feeds the remainder while quotient bits fill from the LSB.
  assign w_shift = {r_rem, r_q[DATA_WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_div};
  assign w_diff  = w_shift[DATA_WIDTH-1:0] - r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_q   <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_start) begin
      r_q   <= i_dividend;
      r_div <= i_divisor;
      r_rem <= '0;
      r_cnt <= CW'(DATA_WIDTH - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_ge ? w_diff : w_shift[DATA_WIDTH-1:0];
      r_q   <= {r_q[DATA_WIDTH-2:0], w_ge};
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_run && (r_cnt == '0);
  assign o_quot = r_q;
  assign o_rem  = r_rem;
endmodule

// File: rtl/accel_div.sv
// Divider accelerator on the WACC/RACC port: write dividend, divisor; read quotient, remainder.
// Optional ACCEL_DIV_SIGNED_EN switches to two's complement operands (truncating division).
module accel_div
  import accel_pkg::*;
#(
  parameter logic [ACCEL_ID_WIDTH-1:0] ACCEL_ID   = ACCEL_ID_DIV,
  parameter int                        DATA_WIDTH = ACCEL_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ACCEL_ID_WIDTH-1:0] accel_id,
  output logic                      accel_can_read,
  output logic                      accel_can_write,
  input  logic                      accel_read_enable,
  output logic [DATA_WIDTH-1:0]     accel_read_data,
  input  logic                      accel_write_enable,
  input  logic [DATA_WIDTH-1:0]     accel_write_data
);
  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_dividend;
  logic                  w_sel;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_start;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_op;
  logic [DATA_WIDTH-1:0] w_quot;
  logic [DATA_WIDTH-1:0] w_rem;
  logic [DATA_WIDTH-1:0] w_quot_out;
  logic [DATA_WIDTH-1:0] w_rem_out;

  assign w_sel   = (accel_id == ACCEL_ID);
  assign w_wr    = w_sel && accel_write_enable;
  assign w_rd    = w_sel && accel_read_enable;
  assign w_start = w_wr && (r_state == ST_WAIT_B);

`ifdef ACCEL_DIV_SIGNED_EN
  logic r_neg_a;
  logic r_neg_b;

  // Core only sees magnitudes; signs are reapplied on the read path.
  assign w_op = accel_write_data[DATA_WIDTH-1] ? (~accel_write_data + 1'b1) : accel_write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
    end else begin
      if (w_wr && (r_state == ST_WAIT_A)) r_neg_a <= accel_write_data[DATA_WIDTH-1];
      if (w_start)                        r_neg_b <= accel_write_data[DATA_WIDTH-1];
    end
  end

  assign w_quot_out = (r_neg_a ^ r_neg_b) ? (~w_quot + 1'b1) : w_quot;
  assign w_rem_out  = r_neg_a ? (~w_rem + 1'b1) : w_rem;
`else
  assign w_op       = accel_write_data;
  assign w_quot_out = w_quot;
  assign w_rem_out  = w_rem;
`endif

  accel_div_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend (r_dividend),
    .i_divisor  (w_op),
    .o_done     (w_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_WAIT_A;
      r_dividend <= '0;
    end else begin
      case (r_state)
        ST_WAIT_A: if (w_wr) begin
          r_dividend <= w_op;
          r_state    <= ST_WAIT_B;
        end
        ST_WAIT_B: if (w_wr) r_state <= ST_BUSY;
        ST_BUSY:   if (w_done) r_state <= ST_RES_Q;
        ST_RES_Q:  if (w_rd) r_state <= ST_RES_R;
        ST_RES_R:  if (w_rd) r_state <= ST_WAIT_A;
        default:   r_state <= ST_WAIT_A;
      endcase
    end
  end

  // Outputs are zero when deselected so several accelerators can be OR-ed onto one port.
  always_comb begin
    accel_can_write = w_sel && ((r_state == ST_WAIT_A) || (r_state == ST_WAIT_B));
    accel_can_read  = w_sel && ((r_state == ST_RES_Q) || (r_state == ST_RES_R));
    accel_read_data = '0;
    if (w_sel && (r_state == ST_RES_Q)) accel_read_data = w_quot_out;
    if (w_sel && (r_state == ST_RES_R)) accel_read_data = w_rem_out;
  end
endmodule

// File: tb/tb_accel_div.sv
// Scoreboard bench for accel_div: stimulus queues expected read words, a monitor checks each read.
module tb_accel_div;
  import accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  accel_id = ACCEL_ID_DIV;
  logic        accel_can_read;
  logic        accel_can_write;
  logic        accel_read_enable = 1'b0;
  logic [15:0] accel_read_data;
  logic        accel_write_enable = 1'b0;
  logic [15:0] accel_write_data = '0;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  accel_div #(.ACCEL_ID(ACCEL_ID_DIV), .DATA_WIDTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .accel_id           (accel_id),
    .accel_can_read     (accel_can_read),
    .accel_can_write    (accel_can_write),
    .accel_read_enable  (accel_read_enable),
    .accel_read_data    (accel_read_data),
    .accel_write_enable (accel_write_enable),
    .accel_write_data   (accel_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_flag(input bit rd, input string nm);
    int n = 0;
    while (!(rd ? accel_can_read : accel_can_write) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for %s", nm, rd ? "can_read" : "can_write");
    end
  endtask

  task automatic wr(input logic [15:0] v, input string nm);
    wait_flag(1'b0, nm);
    accel_write_enable = 1'b1;
    accel_write_data   = v;
    @(posedge clk); #1;
    accel_write_enable = 1'b0;
  endtask

  task automatic rd(input string nm);
    wait_flag(1'b1, nm);
    accel_read_enable = 1'b1;
    @(posedge clk); #1;
    accel_read_enable = 1'b0;
  endtask

  task automatic div(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] q, input logic [15:0] r, input string nm);
    sb.push_back(q);
    sb.push_back(r);
    wr(a, nm); wr(b, nm);
    rd(nm); rd(nm);
    chk({nm, "_can_write_after"}, accel_can_write, 1);
  endtask

  // Monitor: every read the CPU takes is compared against the queued expectation.
  always @(negedge clk) begin
    if (accel_can_read && accel_read_enable) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_unexpected: got %0h expected no read", accel_read_data);
      end else begin
        chk("read_data", accel_read_data, sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_can_write", accel_can_write, 1);
    chk("rst_can_read",  accel_can_read, 0);
    chk("rst_read_data", accel_read_data, 0);

    // 100 / 7 with exact latency measurement
    sb.push_back(16'd14); sb.push_back(16'd2);
    wr(16'd100, "lat"); wr(16'd7, "lat");
    chk("busy_can_write", accel_can_write, 0);
    chk("busy_can_read",  accel_can_read, 0);
    n = 0;
    while (!accel_can_read && n < 100) begin @(posedge clk); #1; n++; end
    chk("latency_edges", n, 16);
    rd("lat"); rd("lat");
    chk("lat_can_write_after", accel_can_write, 1);

    div(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, "ffff_div_1");
    div(16'h0005, 16'h0009, 16'h0000, 16'h0005, "5_div_9");
    div(16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, "div_zero");

    // Deselected: enables ignored, outputs forced to zero
    accel_id = 4'd5;
    accel_write_enable = 1'b1;
    accel_write_data   = 16'h1111;
    repeat (3) begin
      @(negedge clk);
      chk("desel_outputs", {accel_can_write, accel_can_read, accel_read_data}, 0);
    end
    @(posedge clk); #1;
    accel_write_enable = 1'b0;
    accel_id = ACCEL_ID_DIV;
    #1 chk("resel_can_write", accel_can_write, 1);

    // 50 / 5, with the result held across a deselect window
    sb.push_back(16'd10); sb.push_back(16'd0);
    wr(16'd50, "hold"); wr(16'd5, "hold");
    wait_flag(1'b1, "hold");
    accel_id = 4'd5;
    accel_read_enable = 1'b1;
    @(negedge clk);
    chk("hold_desel_data", accel_read_data, 0);
    chk("hold_desel_can_read", accel_can_read, 0);
    @(posedge clk); #1;
    accel_read_enable = 1'b0;
    accel_id = ACCEL_ID_DIV;
    rd("hold"); rd("hold");

    // Reset during BUSY cycle 8 aborts the divide
    wr(16'h1234, "abort"); wr(16'd3, "abort");
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_can_write", accel_can_write, 1);
    chk("abort_can_read",  accel_can_read, 0);
    chk("abort_read_data", accel_read_data, 0);
    repeat (20) @(posedge clk);
    #1 chk("abort_no_result", accel_can_read, 0);
    div(16'd9, 16'd3, 16'd3, 16'd0, "9_div_3");

`ifdef ACCEL_DIV_SIGNED_EN
    div(16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, "s_m7_div_2");
    div(16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, "s_7_div_m2");
    div(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, "s_min_div_m1");
    div(16'hFFF9, 16'h0000, 16'h0001, 16'hFFF9, "s_neg_div_zero");
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
